// File: rtl/snitch_vfpr_wb.sv
// Writeback stage for the TCDM-backed vector FP register file: buffers FPU result beats,
// issues them as single-beat TCDM writes, tracks in-flight writes and flags read hazards.
module snitch_vfpr_wb #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned BufDepth       = 4,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [AddrWidth-1:0]     res_addr_i,
   input  logic [DataWidth-1:0]     res_data_i,
   input  logic                     res_valid_i,
   output logic                     res_ready_o,
   output logic [AddrWidth-1:0]     wr_q_addr_o,
   output logic [DataWidth-1:0]     wr_q_data_o,
   output logic [DataWidth/8-1:0]   wr_q_strb_o,
   output logic                     wr_q_valid_o,
   input  logic                     wr_q_ready_i,
   input  logic                     wr_p_valid_i,
   input  logic [3*AddrWidth-1:0]   haz_addr_i,
   input  logic [2:0]               haz_en_i,
   output logic                     hazard_o,
   output logic                     idle_o,
   output logic                     err_o
);

   localparam int unsigned BufPtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
   localparam int unsigned BufCntW = $clog2(BufDepth + 1);
   localparam int unsigned OutPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned OutCntW = $clog2(MaxOutstanding) + 1;

   // Pointers wrap explicitly so a non power-of-two BufDepth is handled correctly.
   function automatic logic [BufPtrW-1:0] bufPtrInc(input logic [BufPtrW-1:0] ptr);
      return (ptr == BufPtrW'(BufDepth - 1)) ? '0 : ptr + BufPtrW'(1);
   endfunction

   function automatic logic [OutPtrW-1:0] outPtrInc(input logic [OutPtrW-1:0] ptr);
      return (ptr == OutPtrW'(MaxOutstanding - 1)) ? '0 : ptr + OutPtrW'(1);
   endfunction

   logic [AddrWidth-1:0]      bufAddr_q [BufDepth];
   logic [DataWidth-1:0]      bufData_q [BufDepth];
   logic [BufDepth-1:0]       bufValid_q, bufValid_d;
   logic [BufPtrW-1:0]        bufWrPtr_q, bufWrPtr_d;
   logic [BufPtrW-1:0]        bufRdPtr_q, bufRdPtr_d;
   logic [BufCntW-1:0]        bufCount_q, bufCount_d;

   logic [AddrWidth-1:0]      inflAddr_q [MaxOutstanding];
   logic [MaxOutstanding-1:0] inflValid_q, inflValid_d;
   logic [OutPtrW-1:0]        inflWrPtr_q, inflWrPtr_d;
   logic [OutPtrW-1:0]        inflRdPtr_q, inflRdPtr_d;
   logic [OutCntW-1:0]        outstanding_q, outstanding_d;

   logic                      err_q, err_d;

   logic                      bufEmpty;
   logic                      bufFull;
   logic                      outZero;
   logic                      pushBuf;
   logic                      issue;
   logic                      respPop;
   logic                      spurious;
   logic                      hazMatch;

   assign bufEmpty = (bufCount_q == '0);
   assign bufFull  = (bufCount_q == BufCntW'(BufDepth));
   assign outZero  = (outstanding_q == '0);

   assign res_ready_o  = ~bufFull;
   assign pushBuf      = res_valid_i & ~bufFull;
   assign wr_q_valid_o = ~bufEmpty & (outstanding_q < OutCntW'(MaxOutstanding));
   assign issue        = wr_q_valid_o & wr_q_ready_i;
   assign wr_q_addr_o  = bufAddr_q[bufRdPtr_q];
   assign wr_q_data_o  = bufData_q[bufRdPtr_q];
   assign wr_q_strb_o  = '1;

   // A response arriving together with an issue is accepted even with nothing in flight.
   assign respPop  = wr_p_valid_i & (~outZero | issue);
   assign spurious = wr_p_valid_i & outZero & ~issue;

   assign idle_o = bufEmpty & outZero;
   assign err_o  = err_q;

   always_comb begin
      hazMatch = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (haz_en_i[i]) begin
            for (int unsigned b = 0; b < BufDepth; b++) begin
               if (bufValid_q[b] && (bufAddr_q[b] == haz_addr_i[i*AddrWidth +: AddrWidth])) begin
                  hazMatch = 1'b1;
               end
            end
            for (int unsigned o = 0; o < MaxOutstanding; o++) begin
               if (inflValid_q[o] && (inflAddr_q[o] == haz_addr_i[i*AddrWidth +: AddrWidth])) begin
                  hazMatch = 1'b1;
               end
            end
         end
      end
   end

   assign hazard_o = hazMatch;

   always_comb begin
      bufValid_d = bufValid_q;
      bufWrPtr_d = bufWrPtr_q;
      bufRdPtr_d = bufRdPtr_q;
      bufCount_d = bufCount_q;
      if (issue) begin
         bufValid_d[bufRdPtr_q] = 1'b0;
         bufRdPtr_d             = bufPtrInc(bufRdPtr_q);
      end
      if (pushBuf) begin
         bufValid_d[bufWrPtr_q] = 1'b1;
         bufWrPtr_d             = bufPtrInc(bufWrPtr_q);
      end
      case ({pushBuf, issue})
         2'b10:   bufCount_d = bufCount_q + BufCntW'(1);
         2'b01:   bufCount_d = bufCount_q - BufCntW'(1);
         default: bufCount_d = bufCount_q;
      endcase
   end

   // Set before clear, so an issue and response that meet on an empty tracker cancel out.
   always_comb begin
      inflValid_d   = inflValid_q;
      inflWrPtr_d   = inflWrPtr_q;
      inflRdPtr_d   = inflRdPtr_q;
      outstanding_d = outstanding_q;
      err_d         = err_q | spurious;
      if (issue) begin
         inflValid_d[inflWrPtr_q] = 1'b1;
         inflWrPtr_d              = outPtrInc(inflWrPtr_q);
      end
      if (respPop) begin
         inflValid_d[inflRdPtr_q] = 1'b0;
         inflRdPtr_d              = outPtrInc(inflRdPtr_q);
      end
      case ({issue, respPop})
         2'b10:   outstanding_d = outstanding_q + OutCntW'(1);
         2'b01:   outstanding_d = outstanding_q - OutCntW'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned b = 0; b < BufDepth; b++) begin
            bufAddr_q[b] <= '0;
            bufData_q[b] <= '0;
         end
         for (int unsigned o = 0; o < MaxOutstanding; o++) begin
            inflAddr_q[o] <= '0;
         end
         bufValid_q    <= '0;
         bufWrPtr_q    <= '0;
         bufRdPtr_q    <= '0;
         bufCount_q    <= '0;
         inflValid_q   <= '0;
         inflWrPtr_q   <= '0;
         inflRdPtr_q   <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
      end else begin
         if (pushBuf) begin
            bufAddr_q[bufWrPtr_q] <= res_addr_i;
            bufData_q[bufWrPtr_q] <= res_data_i;
         end
         if (issue) begin
            inflAddr_q[inflWrPtr_q] <= wr_q_addr_o;
         end
         bufValid_q    <= bufValid_d;
         bufWrPtr_q    <= bufWrPtr_d;
         bufRdPtr_q    <= bufRdPtr_d;
         bufCount_q    <= bufCount_d;
         inflValid_q   <= inflValid_d;
         inflWrPtr_q   <= inflWrPtr_d;
         inflRdPtr_q   <= inflRdPtr_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

endmodule

// File: tb/tb_snitch_vfpr_wb.sv
// Scoreboard bench for snitch_vfpr_wb: a queue-based model of the buffer and in-flight
// writes predicts every output each cycle, and issued writes are matched in push order.
module tb_snitch_vfpr_wb;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int SW = DW / 8;
   localparam int BD = 4;
   localparam int MO = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_ni;
   logic [AW-1:0]   res_addr_i;
   logic [DW-1:0]   res_data_i;
   logic            res_valid_i;
   logic            res_ready_o;
   logic [AW-1:0]   wr_q_addr_o;
   logic [DW-1:0]   wr_q_data_o;
   logic [SW-1:0]   wr_q_strb_o;
   logic            wr_q_valid_o;
   logic            wr_q_ready_i;
   logic            wr_p_valid_i;
   logic [3*AW-1:0] haz_addr_i;
   logic [2:0]      haz_en_i;
   logic            hazard_o;
   logic            idle_o;
   logic            err_o;

   always #5 clk = ~clk;

   snitch_vfpr_wb #(
      .AddrWidth(AW), .DataWidth(DW), .BufDepth(BD), .MaxOutstanding(MO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .res_addr_i(res_addr_i), .res_data_i(res_data_i),
      .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
      .wr_q_addr_o(wr_q_addr_o), .wr_q_data_o(wr_q_data_o), .wr_q_strb_o(wr_q_strb_o),
      .wr_q_valid_o(wr_q_valid_o), .wr_q_ready_i(wr_q_ready_i),
      .wr_p_valid_i(wr_p_valid_i),
      .haz_addr_i(haz_addr_i), .haz_en_i(haz_en_i),
      .hazard_o(hazard_o), .idle_o(idle_o), .err_o(err_o)
   );

   // Reference model: what is buffered, what is in flight, and what must come out next.
   beat_t         bufQ[$];
   beat_t         expQ[$];
   beat_t         pendQ[$];
   logic [AW-1:0] flightQ[$];
   bit            mErr = 1'b0;

   int checks = 0;
   int errors = 0;
   int issueCount = 0;
   int acceptCount = 0;
   int consumed = 0;

   int              qMode = 1;
   int              respMode = 0;
   bit              forceResp = 1'b0;
   bit              randPush = 1'b0;
   bit              randHaz = 1'b0;
   logic [3*AW-1:0] hazAddrK = '0;
   logic [2:0]      hazEnK = 3'b000;

   logic [AW-1:0] addrPool [8] = '{32'h0000_0008, 32'h8000_0008, 32'h0000_0010, 32'h0000_0018,
                                   32'h0000_0080, 32'h0000_0088, 32'h0000_0100, 32'h0001_0008};

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit modelHazard();
      bit hit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (haz_en_i[i]) begin
            foreach (bufQ[k]) if (bufQ[k].addr == haz_addr_i[i*AW +: AW]) hit = 1'b1;
            foreach (flightQ[k]) if (flightQ[k] == haz_addr_i[i*AW +: AW]) hit = 1'b1;
         end
      end
      return hit;
   endfunction

   function automatic logic [AW-1:0] pickAddr();
      return addrPool[$urandom_range(7)];
   endfunction

   // Checks the current cycle against the model, then advances the model by the coming edge.
   always @(negedge clk) begin : monitor
      beat_t head;
      beat_t want;
      bit    mReady;
      bit    mValid;
      bit    mIssue;
      if (!rst_ni) begin
         bufQ.delete();
         flightQ.delete();
         expQ.delete();
         mErr = 1'b0;
      end
      mReady = (bufQ.size() < BD);
      mValid = (bufQ.size() > 0) && (flightQ.size() < MO);
      checkOutput("res_ready", 64'(res_ready_o), 64'(mReady));
      checkOutput("q_valid", 64'(wr_q_valid_o), 64'(mValid));
      checkOutput("hazard", 64'(hazard_o), 64'(modelHazard()));
      checkOutput("idle", 64'(idle_o), 64'((bufQ.size() == 0) && (flightQ.size() == 0)));
      checkOutput("err", 64'(err_o), 64'(mErr));
      if (mValid) begin
         head = bufQ[0];
         checkOutput("head_addr", 64'(wr_q_addr_o), 64'(head.addr));
         checkOutput("head_data", wr_q_data_o, head.data);
         checkOutput("strb", 64'(wr_q_strb_o), 64'(8'hFF));
      end
      if (rst_ni && wr_q_valid_o && wr_q_ready_i) begin
         issueCount++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_unexpected actual=0x%0h required=no write at %0t", wr_q_addr_o, $time);
         end else begin
            want = expQ.pop_front();
            checkOutput("sb_addr", 64'(wr_q_addr_o), 64'(want.addr));
            checkOutput("sb_data", wr_q_data_o, want.data);
         end
      end
      if (rst_ni) begin
         mIssue = mValid && wr_q_ready_i;
         if (mIssue) begin
            head = bufQ.pop_front();
            flightQ.push_back(head.addr);
         end
         if (res_valid_i && mReady) begin
            head.addr = res_addr_i;
            head.data = res_data_i;
            bufQ.push_back(head);
            expQ.push_back(head);
            acceptCount++;
         end
         if (wr_p_valid_i) begin
            if (flightQ.size() > 0) void'(flightQ.pop_front());
            else mErr = 1'b1;
         end
      end
   end

   task automatic applyStimulus();
      while (consumed < acceptCount) begin
         if (pendQ.size() > 0) pendQ.delete(0);
         consumed++;
      end
      res_valid_i = (pendQ.size() > 0) && (!randPush || ($urandom_range(3) != 0));
      if (pendQ.size() > 0) begin
         res_addr_i = pendQ[0].addr;
         res_data_i = pendQ[0].data;
      end
      case (qMode)
         0:       wr_q_ready_i = 1'b0;
         1:       wr_q_ready_i = 1'b1;
         default: wr_q_ready_i = 1'($urandom_range(1));
      endcase
      if (forceResp) begin
         wr_p_valid_i = 1'b1;
         forceResp    = 1'b0;
      end else begin
         case (respMode)
            0:       wr_p_valid_i = 1'b0;
            1:       wr_p_valid_i = (flightQ.size() > 0) && ($urandom_range(1) == 1);
            default: wr_p_valid_i = (flightQ.size() > 0);
         endcase
      end
      if (randHaz) begin
         for (int i = 0; i < 3; i++) haz_addr_i[i*AW +: AW] = pickAddr();
         haz_en_i = 3'($urandom_range(7));
      end else begin
         haz_addr_i = hazAddrK;
         haz_en_i   = hazEnK;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         applyStimulus();
      end
   endtask

   task automatic pushBeat(input logic [AW-1:0] addr, input logic [DW-1:0] data);
      beat_t b;
      b.addr = addr;
      b.data = data;
      pendQ.push_back(b);
   endtask

   task automatic waitIdle(input int budget);
      int n = 0;
      while (!(bufQ.size() == 0 && flightQ.size() == 0 && pendQ.size() == 0) && n < budget) begin
         tick(1);
         n++;
      end
      checkOutput("drain_in_budget", 64'(n < budget), 64'(1));
   endtask

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int base;
      res_addr_i   = '0;
      res_data_i   = '0;
      res_valid_i  = 1'b0;
      wr_q_ready_i = 1'b0;
      wr_p_valid_i = 1'b0;
      haz_addr_i   = '0;
      haz_en_i     = '0;
      rst_ni       = 1'b1;
      #2 rst_ni    = 1'b0;
      tick(2);
      #3;
      checkOutput("rst_res_ready", 64'(res_ready_o), 64'(1));
      checkOutput("rst_q_valid", 64'(wr_q_valid_o), 64'(0));
      checkOutput("rst_hazard", 64'(hazard_o), 64'(0));
      checkOutput("rst_idle", 64'(idle_o), 64'(1));
      checkOutput("rst_err", 64'(err_o), 64'(0));
      checkOutput("rst_q_addr", 64'(wr_q_addr_o), 64'(0));
      checkOutput("rst_q_data", wr_q_data_o, 64'(0));
      @(posedge clk);
      #1 rst_ni = 1'b1;
      applyStimulus();
      tick(2);

      $display("[TB] single write");
      qMode = 1;
      respMode = 0;
      pushBeat(32'h40, 64'hDEAD_BEEF_0123_4567);
      tick(3);
      #3 checkOutput("single_not_idle", 64'(idle_o), 64'(0));
      forceResp = 1'b1;
      tick(3);
      #3 checkOutput("single_idle", 64'(idle_o), 64'(1));

      $display("[TB] backpressure");
      qMode = 0;
      for (int k = 0; k < 5; k++) pushBeat(32'h100 + 32'(8 * k), {32'hCAFE_0000, 32'(k)});
      tick(8);
      #3;
      checkOutput("bp_full", 64'(res_ready_o), 64'(0));
      checkOutput("bp_head", 64'(wr_q_addr_o), 64'(32'h100));
      qMode = 1;
      respMode = 2;
      waitIdle(60);

      $display("[TB] outstanding cap");
      respMode = 0;
      base = issueCount;
      for (int k = 0; k < 6; k++) pushBeat(32'h300 + 32'(8 * k), {32'hBEEF_0000, 32'(k)});
      tick(14);
      #3;
      checkOutput("cap_issues", 64'(issueCount - base), 64'(4));
      checkOutput("cap_valid", 64'(wr_q_valid_o), 64'(0));
      forceResp = 1'b1;
      tick(3);
      #3 checkOutput("cap_one_more", 64'(issueCount - base), 64'(5));
      respMode = 2;
      waitIdle(60);

      $display("[TB] hazard");
      respMode = 0;
      hazAddrK = {32'h0, 32'h80, 32'h0};
      hazEnK = 3'b010;
      pushBeat(32'h80, 64'h1111_2222_3333_4444);
      tick(4);
      #3 checkOutput("haz_pending", 64'(hazard_o), 64'(1));
      forceResp = 1'b1;
      tick(2);
      #3 checkOutput("haz_cleared", 64'(hazard_o), 64'(0));
      hazEnK = 3'b000;
      pushBeat(32'h80, 64'h5555_6666_7777_8888);
      tick(4);
      #3 checkOutput("haz_disabled", 64'(hazard_o), 64'(0));
      respMode = 2;
      waitIdle(60);

      $display("[TB] simultaneous issue and response");
      respMode = 0;
      hazAddrK = {32'h0, 32'h208, 32'h200};
      hazEnK = 3'b011;
      pushBeat(32'h200, 64'hA0);
      pushBeat(32'h208, 64'hA1);
      tick(5);
      qMode = 0;
      pushBeat(32'h210, 64'hA2);
      tick(3);
      base = issueCount;
      qMode = 1;
      forceResp = 1'b1;
      tick(1);
      qMode = 0;
      tick(3);
      #3;
      checkOutput("sim_issue", 64'(issueCount - base), 64'(1));
      checkOutput("sim_haz_younger", 64'(hazard_o), 64'(1));
      hazEnK = 3'b001;
      tick(1);
      #3 checkOutput("sim_oldest_gone", 64'(hazard_o), 64'(0));
      hazEnK = 3'b000;
      qMode = 1;
      respMode = 2;
      waitIdle(60);

      $display("[TB] spurious response and reset");
      respMode = 0;
      forceResp = 1'b1;
      tick(3);
      #3 checkOutput("spur_err", 64'(err_o), 64'(1));
      qMode = 0;
      pushBeat(32'h400, 64'hB0);
      pushBeat(32'h408, 64'hB1);
      tick(4);
      #3;
      checkOutput("spur_err_sticky", 64'(err_o), 64'(1));
      checkOutput("pre_rst_valid", 64'(wr_q_valid_o), 64'(1));
      @(posedge clk);
      #1 rst_ni = 1'b0;
      pendQ.delete();
      consumed = acceptCount;
      applyStimulus();
      #3;
      checkOutput("mid_rst_idle", 64'(idle_o), 64'(1));
      checkOutput("mid_rst_valid", 64'(wr_q_valid_o), 64'(0));
      checkOutput("mid_rst_err", 64'(err_o), 64'(0));
      tick(2);
      @(posedge clk);
      #1 rst_ni = 1'b1;
      consumed = acceptCount;
      applyStimulus();
      tick(2);

      $display("[TB] randomized traffic");
      randPush = 1'b1;
      randHaz = 1'b1;
      qMode = 2;
      respMode = 1;
      for (int c = 0; c < 800; c++) begin
         if (pendQ.size() < 3 && $urandom_range(1) == 1) pushBeat(pickAddr(), {$urandom, $urandom});
         tick(1);
      end
      randPush = 1'b0;
      qMode = 1;
      respMode = 2;
      waitIdle(200);
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
